// File: rtl/video_types.sv
// Shared video-subsystem types: LCD mode encoding, line counts and the
// default scanline timing used by the timing controller.
package video_types;

  localparam int LCD_LINES      = 154;
  localparam int LCD_LINES_BITS = 8;

  localparam int DEF_DOTS_PER_LINE = 456;
  localparam int DEF_OAM_DOTS      = 80;
  localparam int DEF_XFER_DOTS     = 172;
  localparam int DEF_VISIBLE_LINES = 144;

  typedef enum logic [1:0] {
    HBLANK = 2'd0,
    VBLANK = 2'd1,
    OAM    = 2'd2,
    XFER   = 2'd3
  } LcdMode;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_OAM,
    ST_XFER,
    ST_HBLANK,
    ST_VBLANK
  } lcd_state_e;

endpackage

// File: rtl/lcd_timing_ctrl.sv
// Scanline/mode sequencer: dot and line counters, LCD mode, drawline strobe,
// VBlank/STAT interrupt requests and CPU OAM/VRAM lock generation.
module lcd_timing_ctrl
  import video_types::*;
#(
  parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int OAM_DOTS      = DEF_OAM_DOTS,
  parameter int XFER_DOTS     = DEF_XFER_DOTS,
  parameter int VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int TOTAL_LINES   = LCD_LINES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ien,
  output logic [1:0] mode,
  output logic [7:0] ly,
  output logic       lyc_match,
  output logic       drawline,
  output logic       render_complete,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       oam_lock,
  output logic       vram_lock
);

  localparam logic [8:0] DOT_LAST     = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] XFER_START   = 9'(OAM_DOTS);
  localparam logic [8:0] HBLANK_START = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [LCD_LINES_BITS-1:0] LY_LAST   = LCD_LINES_BITS'(TOTAL_LINES - 1);
  localparam logic [LCD_LINES_BITS-1:0] LY_VBLANK = LCD_LINES_BITS'(VISIBLE_LINES);

  lcd_state_e                state_q, state_d;
  logic [8:0]                dot_q, dot_d;
  logic [LCD_LINES_BITS-1:0] ly_q, ly_d;
  logic                      line_wrap;
  logic                      lyc_match_q, lyc_match_d;
  logic                      drawline_q, drawline_d;
  logic                      frame_q, frame_d;
  logic                      stat_prev_q, stat_prev_d;
  logic                      stat_irq_q, stat_irq_d;
  logic                      stat_line;
  LcdMode                    mode_cur;

  always_comb begin
    state_d   = state_q;
    dot_d     = dot_q;
    ly_d      = ly_q;
    line_wrap = 1'b0;
    if (!lcd_enable) begin
      state_d = ST_OFF;
      dot_d   = '0;
      ly_d    = '0;
    end else if (dot_en) begin
      if (state_q == ST_OFF) begin
        state_d = ST_OAM;
        dot_d   = '0;
        ly_d    = '0;
      end else begin
        line_wrap = (dot_q == DOT_LAST);
        dot_d     = line_wrap ? '0 : dot_q + 9'd1;
        if (line_wrap) ly_d = (ly_q == LY_LAST) ? '0 : ly_q + 1'b1;
        case (state_q)
          ST_OAM:    if (dot_d == XFER_START) state_d = ST_XFER;
          ST_XFER:   if (dot_d == HBLANK_START) state_d = ST_HBLANK;
          ST_HBLANK: if (line_wrap) state_d = (ly_d == LY_VBLANK) ? ST_VBLANK : ST_OAM;
          ST_VBLANK: if (line_wrap && ly_d == '0) state_d = ST_OAM;
          default:   state_d = ST_OFF;
        endcase
      end
    end
  end

  always_comb begin
    case (state_q)
      ST_OAM:    mode_cur = OAM;
      ST_XFER:   mode_cur = XFER;
      ST_VBLANK: mode_cur = VBLANK;
      default:   mode_cur = HBLANK;
    endcase
    // OFF reports mode 0 but must never drive the STAT line
    stat_line = (state_q != ST_OFF) &&
                ((stat_ien[3] && lyc_match_q)    ||
                 (stat_ien[2] && mode_cur == OAM)    ||
                 (stat_ien[1] && mode_cur == VBLANK) ||
                 (stat_ien[0] && mode_cur == HBLANK));
    drawline_d  = (state_q == ST_OAM) && (state_d == ST_XFER);
    frame_d     = (state_q == ST_HBLANK) && (state_d == ST_VBLANK);
    lyc_match_d = (ly_d == lyc);
    stat_prev_d = lcd_enable && stat_line;
    stat_irq_d  = stat_prev_d && !stat_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_OFF;
      dot_q       <= '0;
      ly_q        <= '0;
      lyc_match_q <= (lyc == 8'd0);
      drawline_q  <= 1'b0;
      frame_q     <= 1'b0;
      stat_prev_q <= 1'b0;
      stat_irq_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dot_q       <= dot_d;
      ly_q        <= ly_d;
      lyc_match_q <= lyc_match_d;
      drawline_q  <= drawline_d;
      frame_q     <= frame_d;
      stat_prev_q <= stat_prev_d;
      stat_irq_q  <= stat_irq_d;
    end
  end

  assign mode            = mode_cur;
  assign ly              = ly_q;
  assign lyc_match       = lyc_match_q;
  assign drawline        = drawline_q;
  assign render_complete = frame_q;
  assign vblank_irq      = frame_q;
  assign stat_irq        = stat_irq_q;
  assign oam_lock        = (state_q == ST_OAM) || (state_q == ST_XFER);
  assign vram_lock       = (state_q == ST_XFER);

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Bench for lcd_timing_ctrl: frame-position reference model checked every
// cycle, plus directed literal checks of the key timing points.
module tb_lcd_timing_ctrl;

  localparam int DPL   = 456;
  localparam int FRAME = 154 * DPL;

  logic       clk = 1'b0;
  logic       reset_n, dot_en, lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ien;
  logic [1:0] mode;
  logic [7:0] ly;
  logic       lyc_match, drawline, render_complete, vblank_irq, stat_irq;
  logic       oam_lock, vram_lock;

  int total = 0;
  int bad   = 0;

  lcd_timing_ctrl dut (
    .clk(clk), .reset_n(reset_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
    .lyc(lyc), .stat_ien(stat_ien), .mode(mode), .ly(ly), .lyc_match(lyc_match),
    .drawline(drawline), .render_complete(render_complete), .vblank_irq(vblank_irq),
    .stat_irq(stat_irq), .oam_lock(oam_lock), .vram_lock(vram_lock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the frame, mode derived from it.
  bit m_run, m_draw, m_rend, m_lmatch, m_irq, m_prev_line;
  int m_pos;
  bit chk_on = 1'b0;

  function automatic int exp_mode(input bit run, input int pos);
    if (!run) return 0;
    if (pos / DPL >= 144) return 1;
    if (pos % DPL < 80) return 2;
    if (pos % DPL < 252) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    bit line;
    int md;
    md   = exp_mode(m_run, m_pos);
    line = m_run && ((stat_ien[3] && m_lmatch) || (stat_ien[2] && md == 2) ||
                     (stat_ien[1] && md == 1) || (stat_ien[0] && md == 0));
    m_draw = 1'b0;
    m_rend = 1'b0;
    if (!reset_n || !lcd_enable) begin
      m_run = 1'b0; m_pos = 0; m_irq = 1'b0; m_prev_line = 1'b0;
    end else begin
      m_irq       = line && !m_prev_line;
      m_prev_line = line;
      if (dot_en) begin
        if (!m_run) begin
          m_run = 1'b1; m_pos = 0;
        end else begin
          m_pos  = (m_pos + 1) % FRAME;
          m_draw = (m_pos % DPL == 80) && (m_pos / DPL < 144);
          m_rend = (m_pos == 144 * DPL);
        end
      end
    end
    m_lmatch = ((m_pos / DPL) == int'(lyc));
  end

  always @(negedge clk) begin
    if (chk_on) begin
      int md;
      md = exp_mode(m_run, m_pos);
      chk("mode", int'(mode), md);
      chk("ly", int'(ly), m_pos / DPL);
      chk("lyc_match", int'(lyc_match), int'(m_lmatch));
      chk("drawline", int'(drawline), int'(m_draw));
      chk("render_complete", int'(render_complete), int'(m_rend));
      chk("vblank_irq", int'(vblank_irq), int'(m_rend));
      chk("stat_irq", int'(stat_irq), int'(m_irq));
      chk("oam_lock", int'(oam_lock), int'(md == 2 || md == 3));
      chk("vram_lock", int'(vram_lock), int'(md == 3));
    end
  end

  // Runs with dot_en=1 from an OFF state; checks line-0 start and drawline.
  task automatic restart_check(input string tag);
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_mode_start"}, int'(mode), 2);
        chk({tag, "_ly_start"}, int'(ly), 0);
      end
      if (k == 81) chk({tag, "_drawline_81"}, int'(drawline), 1);
    end
  endtask

  int n_draw, n_vb, vb_cyc, n_s1, s1_cyc, n_s2, n_lm, first_d;

  initial begin
    reset_n = 1'b0; dot_en = 1'b0; lcd_enable = 1'b0; lyc = 8'd5; stat_ien = 4'b1000;
    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode), 0);
    chk("rst_ly", int'(ly), 0);
    chk("rst_oam_lock", int'(oam_lock), 0);
    chk("rst_vram_lock", int'(vram_lock), 0);
    chk_on = 1'b1;

    // Full frame with dot_en held high
    n_draw = 0; n_vb = 0; vb_cyc = 0; n_s1 = 0; s1_cyc = 0; n_s2 = 0; n_lm = 0;
    lcd_enable = 1'b1; dot_en = 1'b1; reset_n = 1'b1;
    for (int k = 1; k <= 70300; k++) begin
      @(negedge clk);
      if (drawline && k <= FRAME) n_draw++;
      if (vblank_irq) begin n_vb++; vb_cyc = k; end
      if (lyc_match && k <= FRAME) n_lm++;
      if (stat_irq) begin
        if (k <= 4110) begin n_s1++; if (s1_cyc == 0) s1_cyc = k; end
        else n_s2++;
      end
      if (k == 4110) stat_ien = 4'b0011;
      if (k == 80)    chk("mode_c80", int'(mode), 2);
      if (k == 81)    chk("mode_c81", int'(mode), 3);
      if (k == 81)    chk("drawline_c81", int'(drawline), 1);
      if (k == 252)   chk("mode_c252", int'(mode), 3);
      if (k == 253)   chk("mode_c253", int'(mode), 0);
      if (k == 456)   chk("ly_c456", int'(ly), 0);
      if (k == 457)   chk("ly_c457", int'(ly), 1);
      if (k == 2281)  chk("lyc_match_c2281", int'(lyc_match), 1);
      if (k == 65666) chk("no_stat_at_vblank", int'(stat_irq), 0);
      if (k == FRAME) chk("ly_c70224", int'(ly), 153);
      if (k == FRAME + 1) chk("ly_wrap", int'(ly), 0);
    end
    chk("draw_per_frame", n_draw, 144);
    chk("vblank_count", n_vb, 1);
    chk("vblank_cycle", vb_cyc, 65665);
    chk("lyc_match_cycles", n_lm, 456);
    chk("lyc_irq_count", n_s1, 1);
    chk("lyc_irq_cycle", s1_cyc, 2282);
    chk("hblank_irq_count", n_s2, 135);

    // dot_en every 4th cycle
    reset_n = 1'b0; dot_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n_draw = 0; first_d = 0;
    for (int k = 1; k <= 3700; k++) begin
      dot_en = ((k % 4) == 1);
      @(negedge clk);
      if (drawline) begin n_draw++; if (first_d == 0) first_d = k; end
      if (k == 320) chk("slow_mode_c320", int'(mode), 2);
      if (k == 321) chk("slow_mode_c321", int'(mode), 3);
    end
    chk("slow_first_drawline", first_d, 321);
    chk("slow_drawline_cycles", n_draw, 2);

    // Randomized traffic
    for (int k = 0; k < 6000; k++) begin
      dot_en     = ($urandom_range(0, 3) != 0);
      lcd_enable = ($urandom_range(0, 1999) != 0);
      reset_n    = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 99) == 0) lyc = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) stat_ien = 4'($urandom_range(0, 15));
      @(negedge clk);
    end

    // Enable drop mid-line, then reset pulse mid-transfer
    reset_n = 1'b1; lcd_enable = 1'b0; dot_en = 1'b1;
    @(negedge clk);
    lcd_enable = 1'b1;
    repeat (557) @(negedge clk);
    chk("pre_drop_ly", int'(ly), 1);
    lcd_enable = 1'b0;
    @(negedge clk);
    chk("drop_mode", int'(mode), 0);
    chk("drop_ly", int'(ly), 0);
    chk("drop_oam_lock", int'(oam_lock), 0);
    chk("drop_vram_lock", int'(vram_lock), 0);
    lcd_enable = 1'b1;
    restart_check("reenable");
    repeat (60) @(negedge clk);
    chk("pre_reset_vram_lock", int'(vram_lock), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("reset_mode", int'(mode), 0);
    chk("reset_vram_lock", int'(vram_lock), 0);
    reset_n = 1'b1;
    restart_check("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
